// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported stalling data memory.
// Port 0 is the CPU load/store path, port 1 the loader/debug DMA path.
module data_mem_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    input  logic [3:0]  mask0,
    input  logic [3:0]  mask1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

    state_t      state_q, state_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic        rr_last_q, rr_last_d;
    logic        stall_seen_q, stall_seen_d;
    logic [3:0]  timer_q, timer_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        memwrite_q, memwrite_d;
    logic        memread_q, memread_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        grant1;

    // Port 1 wins when alone, or on a round-robin tie when port 0 was served last.
    always_comb begin
        grant1 = req1 & (~req0 | ((PRIORITY_MODE == 0) & ~rr_last_q));
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        we_d         = we_q;
        rr_last_d    = rr_last_q;
        stall_seen_d = stall_seen_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        memwrite_d   = memwrite_q;
        memread_d    = memread_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    win_d      = grant1;
                    we_d       = grant1 ? we1 : we0;
                    addr_d     = grant1 ? addr1 : addr0;
                    wdata_d    = grant1 ? wdata1 : wdata0;
                    mask_d     = grant1 ? mask1 : mask0;
                    memwrite_d = grant1 ? we1 : we0;
                    memread_d  = grant1 ? ~we1 : ~we0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                memwrite_d   = 1'b0;
                memread_d    = 1'b0;
                stall_seen_d = 1'b0;
                timer_d      = 4'd0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                stall_seen_d = stall_seen_q | mem_clk_stall;
                if (stall_seen_q && !mem_clk_stall) begin
                    if (!we_q && win_q)  rdata1_d = mem_read_data;
                    if (!we_q && !win_q) rdata0_d = mem_read_data;
                    done0_d = ~win_q;
                    done1_d = win_q;
                    state_d = S_RESP;
                end else if (timer_q == TIMEOUT_L) begin
                    done0_d = ~win_q;
                    done1_d = win_q;
                    err0_d  = ~win_q;
                    err1_d  = win_q;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            S_RESP: begin
                rr_last_d = win_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            rr_last_q    <= 1'b1;
            stall_seen_q <= 1'b0;
            timer_q      <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            mask_q       <= 4'd0;
            memwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            we_q         <= we_d;
            rr_last_q    <= rr_last_d;
            stall_seen_q <= stall_seen_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            memwrite_q   <= memwrite_d;
            memread_q    <= memread_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign done0          = done0_q;
    assign done1          = done1_q;
    assign err0           = err0_q;
    assign err1           = err1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_sign_mask  = mask_q;
    assign mem_memwrite   = memwrite_q;
    assign mem_memread    = memread_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: vector table plus hand-written
// arbitration, timeout and reset sequences.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  mask0, mask1;
    logic        done0, done1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread, mem_clk_stall;
    logic [3:0]  mem_sign_mask;

    logic        fp_req0, fp_req1;
    logic        fp_done0, fp_done1, fp_err0, fp_err1, fp_busy;
    logic [31:0] fp_rdata0, fp_rdata1, fp_mem_addr, fp_mem_write_data;
    logic        fp_mem_memwrite, fp_mem_memread;
    logic [3:0]  fp_mem_sign_mask;
    logic [31:0] fp_mem_read_data;
    logic        fp_mem_clk_stall;

    data_mem_arbiter dut (
        .clk(clk), .reset(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .mask0(mask0), .mask1(mask1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall), .busy(busy)
    );

    // Fixed-priority instance with a memory that never stalls, so every access times out.
    data_mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(3)) dut_fp (
        .clk(clk), .reset(rst),
        .req0(fp_req0), .req1(fp_req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .mask0(mask0), .mask1(mask1),
        .done0(fp_done0), .done1(fp_done1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .err0(fp_err0), .err1(fp_err1),
        .mem_addr(fp_mem_addr), .mem_write_data(fp_mem_write_data),
        .mem_memwrite(fp_mem_memwrite), .mem_memread(fp_mem_memread),
        .mem_sign_mask(fp_mem_sign_mask), .mem_read_data(fp_mem_read_data),
        .mem_clk_stall(fp_mem_clk_stall), .busy(fp_busy)
    );

    // Memory model: samples a strobe, then holds clk_stall high for stall_len cycles.
    logic [31:0] mem_arr [64];
    int stall_len;
    int stall_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_clk_stall <= 1'b0;
            mem_read_data <= 32'd0;
            stall_cnt     <= 0;
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'd0;
            mem_arr[4]  <= 32'hDEADBEEF;
            mem_arr[12] <= 32'hCAFEF00D;
            mem_arr[13] <= 32'h0BADF00D;
        end else if (mem_memread || mem_memwrite) begin
            if (mem_memwrite) mem_arr[mem_addr[7:2]] <= mem_write_data;
            else              mem_read_data <= mem_arr[mem_addr[7:2]];
            if (stall_len > 0) begin
                mem_clk_stall <= 1'b1;
                stall_cnt     <= stall_len - 1;
            end
        end else if (mem_clk_stall) begin
            if (stall_cnt == 0) mem_clk_stall <= 1'b0;
            else                stall_cnt <= stall_cnt - 1;
        end
    end

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, d0_cnt = 0, d1_cnt = 0;
    logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
    logic [3:0]  last_mask = 4'd0;
    always @(negedge clk) begin
        if (mem_memread) rd_cnt++;
        if (mem_memwrite) wr_cnt++;
        if (mem_memread && mem_memwrite) both_cnt++;
        if (mem_memread || mem_memwrite) begin
            last_addr  = mem_addr;
            last_wdata = mem_write_data;
            last_mask  = mem_sign_mask;
        end
        if (done0) d0_cnt++;
        if (done1) d1_cnt++;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          stall;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs [10];

    task automatic do_txn(input int idx, input vec_t v);
        int r0, w0, b0, n0, n1, cnt;
        bit seen;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        check({p, "_idle"}, {31'd0, busy}, 32'd0);
        stall_len = v.stall;
        if (v.port == 1'b0) begin
            addr0 = v.addr; wdata0 = v.wdata; mask0 = v.mask; we0 = v.we; req0 = 1'b1;
        end else begin
            addr1 = v.addr; wdata1 = v.wdata; mask1 = v.mask; we1 = v.we; req1 = 1'b1;
        end
        r0 = rd_cnt; w0 = wr_cnt; b0 = both_cnt; n0 = d0_cnt; n1 = d1_cnt;
        @(posedge clk);
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            if ((v.port ? done1 : done0) === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk);
                cnt++;
            end
        end
        check({p, "_latency"}, cnt + 1, v.exp_lat);
        if (seen) begin
            check({p, "_rdata"}, v.port ? rdata1 : rdata0, v.exp_rdata);
            check({p, "_err"}, {31'd0, v.port ? err1 : err0}, {31'd0, v.exp_err});
            check({p, "_other_done"}, {31'd0, v.port ? done0 : done1}, 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({p, "_rd_strobes"}, rd_cnt - r0, {31'd0, ~v.we});
        check({p, "_wr_strobes"}, wr_cnt - w0, {31'd0, v.we});
        check({p, "_both_strobes"}, both_cnt - b0, 32'd0);
        check({p, "_mem_addr"}, last_addr, v.addr);
        check({p, "_mem_mask"}, {28'd0, last_mask}, {28'd0, v.mask});
        if (v.we) check({p, "_mem_wdata"}, last_wdata, v.wdata);
        check({p, "_done0_pulses"}, d0_cnt - n0, {31'd0, ~v.port});
        check({p, "_done1_pulses"}, d1_cnt - n1, {31'd0, v.port});
        check({p, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    // Waits for a done on either port of the main instance; returns the port or 2 on timeout.
    task automatic wait_done(output int port);
        int cnt;
        port = 2;
        cnt  = 0;
        while (port == 2 && cnt < 40) begin
            @(negedge clk);
            if (done0 === 1'b1 && done1 === 1'b1) port = 3;
            else if (done0 === 1'b1) port = 0;
            else if (done1 === 1'b1) port = 1;
            else begin
                @(posedge clk);
                cnt++;
            end
        end
    endtask

    initial begin
        int port, n0, n1, cnt;
        bit seen;
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'b0100, 1, 32'hDEADBEEF, 1'b0, 4};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 4'b1111, 1, 32'h00000000, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        4'b1111, 1, 32'h12345678, 1'b0, 4};
        vecs[3] = '{1'b0, 1'b0, 32'h30, 32'h0,        4'b0010, 3, 32'hCAFEF00D, 1'b0, 6};
        vecs[4] = '{1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'b1000, 2, 32'hCAFEF00D, 1'b0, 5};
        vecs[5] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'b0100, 1, 32'hA5A5A5A5, 1'b0, 4};
        vecs[6] = '{1'b1, 1'b0, 32'h34, 32'h0,        4'b0001, 2, 32'h0BADF00D, 1'b0, 5};
        vecs[7] = '{1'b0, 1'b0, 32'h30, 32'h0,        4'b0100, 0, 32'hA5A5A5A5, 1'b1, 18};
        vecs[8] = '{1'b0, 1'b0, 32'h30, 32'h0,        4'b0100, 1, 32'hCAFEF00D, 1'b0, 4};
        vecs[9] = '{1'b1, 1'b0, 32'h20, 32'h0,        4'b0101, 1, 32'h12345678, 1'b0, 4};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        mask0 = 4'd0; mask1 = 4'd0;
        fp_req0 = 1'b0; fp_req1 = 1'b0;
        fp_mem_read_data = 32'd0; fp_mem_clk_stall = 1'b0;
        stall_len = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {26'd0, done0, done1, err0, err1, busy, mem_memread | mem_memwrite}, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);
        check("reset_mem_bus", mem_addr | mem_write_data | {28'd0, mem_sign_mask}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_txn(i, vecs[i]);

        // Reset while the strobe is up: it must drop without waiting for a clock edge.
        @(negedge clk);
        stall_len = 0;
        addr0 = 32'h10; we0 = 1'b0; mask0 = 4'b0100; req0 = 1'b1;
        n0 = d0_cnt; n1 = d1_cnt;
        @(posedge clk);
        #1;
        check("issue_strobe", {31'd0, mem_memread}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_issue_strobe", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        check("rst_issue_busy", {31'd0, busy}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset during WAIT, then a tie on release goes to port 0 and alternates.
        @(negedge clk);
        req0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wait_ctrl", {29'd0, busy, mem_memread, mem_memwrite}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_no_done", (d0_cnt - n0) + (d1_cnt - n1), 32'd0);
        stall_len = 1;
        addr1 = 32'h20; we1 = 1'b0; mask1 = 4'b1111; req1 = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_done(port);
            check($sformatf("rr_grant%0d", k), port, k % 2);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(posedge clk);
        end
        repeat (3) @(negedge clk);
        check("rr_idle_after", {31'd0, busy}, 32'd0);

        // Fixed priority: port 0 keeps winning while it keeps requesting.
        @(negedge clk);
        fp_req0 = 1'b1;
        fp_req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            seen = 1'b0;
            while (!seen && cnt < 40) begin
                @(negedge clk);
                if (fp_done0 === 1'b1 || fp_done1 === 1'b1) seen = 1'b1;
                else begin
                    @(posedge clk);
                    cnt++;
                end
            end
            check($sformatf("fp_grant%0d", k), {30'd0, fp_done1, fp_done0}, 32'd1);
            check($sformatf("fp_err%0d", k), {31'd0, fp_err0}, 32'd1);
            if (k == 3) fp_req0 = 1'b0;
            @(posedge clk);
        end
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            if (fp_done0 === 1'b1 || fp_done1 === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk);
                cnt++;
            end
        end
        check("fp_port1_served", {30'd0, fp_done1, fp_done0}, 32'd2);
        check("fp_port1_err", {31'd0, fp_err1}, 32'd1);
        fp_req1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
